// File: rtl/led_status_coder.sv
// Drives the board LED from a heartbeat: mirrors the synchronised beat when no code
// is pending, otherwise flashes the pending code once per beat tick, then a dark gap.
module led_status_coder #(
    parameter int CODE_W    = 4,
    parameter int GAP_TICKS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_in,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_load,
    output logic              led_out,
    output logic              seq_active,
    output logic [CODE_W-1:0] code_cur
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [CODE_W-1:0] CODE_ZERO = {CODE_W{1'b0}};
    localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);
    localparam logic [7:0]        GCNT_LOAD = 8'(GAP_TICKS - 1);

    logic              s1_r, s2_r, s3_r;
    logic              prim_r, armed_r;
    logic              tick_s;
    logic [CODE_W-1:0] pending_r;
    state_t            state_r, state_s;
    logic [CODE_W-1:0] cur_r, cur_s;
    logic [CODE_W-1:0] cnt_r, cnt_s;
    logic [7:0]        gcnt_r, gcnt_s;
    logic              led_r, led_s;
    logic              active_r;
    logic [CODE_W-1:0] code_cur_r;

    // Beat synchroniser and edge history; armed_r blocks a fake rising edge when
    // beat_in is already high at reset release (it must first be seen low).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r    <= 1'b0;
            s2_r    <= 1'b0;
            s3_r    <= 1'b0;
            prim_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            s1_r    <= beat_in;
            s2_r    <= s1_r;
            s3_r    <= s2_r;
            prim_r  <= 1'b1;
            armed_r <= armed_r | (prim_r & ~s1_r);
        end
    end

    assign tick_s = s2_r & ~s3_r & armed_r;

    // Pending code register: last load wins, never cleared by the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= CODE_ZERO;
        end else if (code_load) begin
            pending_r <= code_in;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Next-state logic; every transition is gated by a beat tick.
    always_comb begin
        state_s = state_r;
        cur_s   = cur_r;
        cnt_s   = cnt_r;
        gcnt_s  = gcnt_r;
        if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (pending_r != CODE_ZERO) begin
                        cur_s   = pending_r;
                        cnt_s   = pending_r;
                        state_s = ST_ON;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ON: begin
                    cnt_s   = cnt_r - CODE_ONE;
                    state_s = ST_OFF;
                end
                ST_OFF: begin
                    if (cnt_r == CODE_ZERO) begin
                        gcnt_s  = GCNT_LOAD;
                        state_s = ST_GAP;
                    end else begin
                        state_s = ST_ON;
                    end
                end
                ST_GAP: begin
                    if (gcnt_r != 8'd0) begin
                        gcnt_s = gcnt_r - 8'd1;
                    end else if (pending_r != CODE_ZERO) begin
                        cur_s   = pending_r;
                        cnt_s   = pending_r;
                        state_s = ST_ON;
                    end else begin
                        cur_s   = CODE_ZERO;
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    cur_s   = CODE_ZERO;
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // LED level for the state being entered; idle mirrors the synchronised beat.
    always_comb begin
        led_s = 1'b0;
        case (state_s)
            ST_ON:   led_s = 1'b1;
            ST_IDLE: led_s = s2_r;
            default: led_s = 1'b0;
        endcase
    end

    // Sequencer registers and registered outputs, all updated on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cur_r      <= CODE_ZERO;
            cnt_r      <= CODE_ZERO;
            gcnt_r     <= 8'd0;
            led_r      <= 1'b0;
            active_r   <= 1'b0;
            code_cur_r <= CODE_ZERO;
        end else begin
            state_r    <= state_s;
            cur_r      <= cur_s;
            cnt_r      <= cnt_s;
            gcnt_r     <= gcnt_s;
            led_r      <= led_s;
            active_r   <= (state_s != ST_IDLE);
            code_cur_r <= cur_s;
        end
    end

    assign led_out    = led_r;
    assign seq_active = active_r;
    assign code_cur   = code_cur_r;

endmodule

// File: tb/tb_led_status_coder.sv
// Randomised bench for led_status_coder: a tick-level sequence model (queue of LED
// levels per beat tick) predicts the outputs, plus directed per-scenario checks.
module tb_led_status_coder;
    localparam int CW  = 4;
    localparam int GAP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          beat_in = 1'b0;
    logic [CW-1:0] code_in = '0;
    logic          code_load = 1'b0;
    logic          led_out;
    logic          seq_active;
    logic [CW-1:0] code_cur;

    int checks   = 0;
    int failures = 0;

    led_status_coder #(.CODE_W(CW), .GAP_TICKS(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .beat_in    (beat_in),
        .code_in    (code_in),
        .code_load  (code_load),
        .led_out    (led_out),
        .seq_active (seq_active),
        .code_cur   (code_cur)
    );

    always #5 clk = ~clk;

    // Heartbeat generator: mode 0 holds, 1 fixed half-period, 2 random half-period.
    int beat_mode = 0;
    int half_cyc  = 4;
    int cur_half  = 4;
    int ph_cnt    = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (beat_mode != 0) begin
                ph_cnt++;
                if (ph_cnt >= cur_half) begin
                    beat_in  = ~beat_in;
                    ph_cnt   = 0;
                    cur_half = (beat_mode == 2) ? int'($urandom_range(6, 3)) : half_cyc;
                end
            end
        end
    end

    // Reference model. h1/h2/h3 are beat samples from 1/2/3 edges ago; a tick is a
    // rise between two samples both taken after reset release.
    int  m_cnt = 0;
    bit  h1, h2, h3;
    int  m_q[$];
    bit  m_active = 1'b0;
    int  m_level = 0;
    int  m_cur = 0;
    int  m_pend = 0;
    bit  m_tick = 1'b0;
    bit  exp_led = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            m_q.delete();
            m_active = 1'b0; m_level = 0; m_cur = 0; m_pend = 0;
            m_tick = 1'b0; exp_led = 1'b0;
        end else begin
            m_tick = (m_cnt >= 3) && h2 && !h3;
            if (m_tick) begin
                if (m_q.size() == 0) begin
                    if (m_pend != 0) begin
                        for (int i = 0; i < m_pend; i++) begin
                            m_q.push_back(1);
                            m_q.push_back(0);
                        end
                        for (int i = 0; i < GAP; i++) m_q.push_back(0);
                        m_cur    = m_pend;
                        m_active = 1'b1;
                    end else begin
                        m_active = 1'b0;
                        m_cur    = 0;
                    end
                end
                if (m_q.size() > 0) m_level = m_q.pop_front();
            end
            exp_led = m_active ? (m_level != 0) : ((m_cnt >= 2) ? h2 : 1'b0);
            h3 = h2; h2 = h1; h1 = beat_in;
            if (m_cnt < 1000000) m_cnt++;
            if (code_load) m_pend = int'(code_in);
        end
    end

    task automatic test_reset();
        beat_mode = 0;
        beat_in   = 1'b1;
        rst       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({led_out, seq_active, code_cur} !== {1'b0, 1'b0, 4'd0}) begin
                failures++;
                $display("FAIL reset_outputs got led=%b act=%b cur=%0d want 0 0 0", led_out, seq_active, code_cur);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        code_in = 4'd5; code_load = 1'b1;
        @(negedge clk);
        code_load = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if ({led_out, seq_active, code_cur} !== {exp_led, m_active, 4'(m_cur)} || seq_active !== 1'b0) begin
                failures++;
                $display("FAIL no_tick_after_release got led=%b act=%b cur=%0d want %b 0 %0d", led_out, seq_active, code_cur, exp_led, m_cur);
            end
        end
        code_in = 4'd0; code_load = 1'b1;
        @(negedge clk);
        code_load = 1'b0;
    endtask

    task automatic test_mirror();
        half_cyc = 8; cur_half = 8; ph_cnt = 0; beat_mode = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({led_out, seq_active, code_cur} !== {exp_led, 1'b0, 4'd0} || m_active) begin
                failures++;
                $display("FAIL mirror got led=%b act=%b cur=%0d want %b 0 0", led_out, seq_active, code_cur, exp_led);
            end
        end
        half_cyc = 4;
    endtask

    task automatic test_code3_reload();
        int idx;
        bit pat3[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bit want_led;
        int want_cur;
        int guard;
        @(negedge clk);
        code_in = 4'd3; code_load = 1'b1;
        @(negedge clk);
        code_load = 1'b0;
        guard = 0;
        while (!m_active && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!m_active) begin
            failures++;
            $display("FAIL code3_start timeout act=%b want 1", seq_active);
        end
        idx = 0; guard = 0;
        while (idx < 44 && guard < 3000) begin
            if (idx < 30) begin
                want_led = pat3[idx % 10]; want_cur = 3;
            end else begin
                want_led = ((idx - 30) < 10) && ((idx - 30) % 2 == 0); want_cur = 5;
            end
            checks++;
            if ({led_out, seq_active, code_cur} !== {want_led, 1'b1, 4'(want_cur)}) begin
                failures++;
                $display("FAIL code3_tick%0d got led=%b act=%b cur=%0d want %b 1 %0d", idx, led_out, seq_active, code_cur, want_led, want_cur);
            end
            if (idx == 22) begin
                code_in = 4'd5; code_load = 1'b1;
            end
            do begin
                @(negedge clk);
                guard++;
                code_load = 1'b0;
                checks++;
                if ({led_out, seq_active, code_cur} !== {exp_led, m_active, 4'(m_cur)}) begin
                    failures++;
                    $display("FAIL code3_model got led=%b act=%b cur=%0d want %b %b %0d", led_out, seq_active, code_cur, exp_led, m_active, m_cur);
                end
            end while (!m_tick && guard < 3000);
            idx++;
        end
    endtask

    task automatic test_zero();
        int idx;
        int guard;
        bit want_led;
        @(negedge clk);
        code_in = 4'd2; code_load = 1'b1;
        @(negedge clk);
        code_load = 1'b0;
        guard = 0;
        while (!(m_tick && m_active && m_cur == 2) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        idx = 0;
        while (idx < 9 && guard < 4000) begin
            if (idx < 8) begin
                want_led = (idx < 4) && (idx % 2 == 0);
                checks++;
                if ({led_out, seq_active, code_cur} !== {want_led, 1'b1, 4'd2}) begin
                    failures++;
                    $display("FAIL zero_tick%0d got led=%b act=%b cur=%0d want %b 1 2", idx, led_out, seq_active, code_cur, want_led);
                end
            end else begin
                checks++;
                if ({seq_active, code_cur} !== {1'b0, 4'd0}) begin
                    failures++;
                    $display("FAIL zero_idle got act=%b cur=%0d want 0 0", seq_active, code_cur);
                end
            end
            if (idx == 1) begin
                code_in = 4'd0; code_load = 1'b1;
            end
            if (idx < 8) begin
                do begin
                    @(negedge clk);
                    guard++;
                    code_load = 1'b0;
                    checks++;
                    if ({led_out, seq_active, code_cur} !== {exp_led, m_active, 4'(m_cur)}) begin
                        failures++;
                        $display("FAIL zero_model got led=%b act=%b cur=%0d want %b %b %0d", led_out, seq_active, code_cur, exp_led, m_active, m_cur);
                    end
                end while (!m_tick && guard < 4000);
            end
            idx++;
        end
        checks++;
        if (idx != 9) begin
            failures++;
            $display("FAIL zero_timeout ticks=%0d want 9", idx);
        end
    endtask

    task automatic test_max();
        int guard;
        int rises;
        bit prev;
        guard = 0;
        while (!(!m_active && m_cnt >= 3 && h2 && !h3) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        code_in = 4'd15; code_load = 1'b1;
        @(negedge clk);
        code_load = 1'b0;
        checks++;
        if (seq_active !== 1'b0) begin
            failures++;
            $display("FAIL load_tick_same_cycle got act=%b want 0", seq_active);
        end
        guard = 0;
        while (!m_active && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        code_in = 4'd0; code_load = 1'b1;
        rises = (led_out === 1'b1 && seq_active === 1'b1) ? 1 : 0;
        prev  = led_out;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            code_load = 1'b0;
            if (led_out === 1'b1 && !prev && seq_active === 1'b1) rises++;
            prev = led_out;
            checks++;
            if ({led_out, seq_active, code_cur} !== {exp_led, m_active, 4'(m_cur)}) begin
                failures++;
                $display("FAIL max_model got led=%b act=%b cur=%0d want %b %b %0d", led_out, seq_active, code_cur, exp_led, m_active, m_cur);
            end
        end while (m_active && guard < 2000);
        checks++;
        if (rises != 15) begin
            failures++;
            $display("FAIL max_flashes got %0d want 15", rises);
        end
    endtask

    task automatic test_rst_gap();
        int guard;
        @(negedge clk);
        code_in = 4'd3; code_load = 1'b1;
        @(negedge clk);
        code_load = 1'b0;
        guard = 0;
        while (!(m_active && m_q.size() > 0 && m_q.size() < GAP) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({led_out, seq_active, code_cur} !== {1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL rst_gap_async got led=%b act=%b cur=%0d want 0 0 0", led_out, seq_active, code_cur);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if ({led_out, seq_active, code_cur} !== {exp_led, 1'b0, 4'd0} || m_active) begin
                failures++;
                $display("FAIL rst_gap_idle got led=%b act=%b cur=%0d want %b 0 0", led_out, seq_active, code_cur, exp_led);
            end
        end
    endtask

    task automatic test_random();
        beat_mode = 2;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            checks++;
            if ({led_out, seq_active, code_cur} !== {exp_led, m_active, 4'(m_cur)}) begin
                failures++;
                $display("FAIL random_model cyc=%0d got led=%b act=%b cur=%0d want %b %b %0d", i, led_out, seq_active, code_cur, exp_led, m_active, m_cur);
            end
            code_load = ($urandom_range(40, 0) == 0);
            if (code_load) code_in = 4'($urandom_range(15, 0));
        end
        code_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mirror();
        test_code3_reload();
        test_zero();
        test_max();
        test_rst_gap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_status_coder.md
LED_STATUS_CODER -- requirements
Module: led_status_coder

Purpose: consumes the square-wave heartbeat and drives the board LED. With no status code pending, the LED mirrors the heartbeat. With a non-zero status code N pending, the LED shows N flashes, then a dark gap, repeating.

Interface
REQ-001 Parameter CODE_W, default 4, width of the status code.
REQ-002 Parameter GAP_TICKS, default 4, number of beat ticks in the inter-sequence gap; legal values 1..255.
REQ-003 clk  input  1  the single system clock; all flops are clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 beat_in  input  1  heartbeat square wave; treated as asynchronous.
REQ-006 code_in  input  CODE_W  status code to display; 0 means none.
REQ-007 code_load  input  1  when high in a cycle, code_in is captured as the pending code.
REQ-008 led_out  output  1  registered LED drive.
REQ-009 seq_active  output  1  high whenever the FSM is not in IDLE.
REQ-010 code_cur  output  CODE_W  code currently being flashed; 0 in IDLE.

Function
REQ-011 beat_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; tick = s2 & ~s3, high for exactly 1 cycle per beat_in rising edge.
REQ-012 pending SHALL load code_in on every cycle code_load=1 (last write wins) and SHALL otherwise hold; pending is never cleared by the FSM.
REQ-013 The FSM SHALL have four states: IDLE, ON, OFF, GAP; all transitions occur only on cycles with tick=1, except reset.
REQ-014 IDLE, on tick with pending!=0: latch cur=pending, set cnt=pending, go to ON.
REQ-015 IDLE, on tick with pending==0: stay in IDLE.
REQ-016 ON, on tick: set cnt=cnt-1 and go to OFF.
REQ-017 OFF, on tick: go to GAP with gcnt=GAP_TICKS-1 if cnt==0, else go to ON.
REQ-018 GAP, on tick with gcnt!=0: decrement gcnt.
REQ-019 GAP, on tick with gcnt==0: if pending!=0, relatch cur and cnt and go to ON; else go to IDLE with cur=0.
REQ-020 A code of N SHALL produce exactly N ON periods of 1 tick each, separated by 1-tick OFF periods. The last OFF plus GAP gives 1+GAP_TICKS dark ticks.
REQ-021 code_load during ON, OFF or GAP SHALL NOT alter cur or cnt; the new code takes effect only at the next sequence start (REQ-014, REQ-019).
REQ-022 Loading code 0 mid-sequence SHALL let the current sequence finish, then return to IDLE.
REQ-023 led_out SHALL be registered and SHALL update on the same edge as the state register, from the next state: 1 for ON, 0 for OFF and GAP, and s2 for IDLE. In IDLE, led_out therefore lags beat_in by 3 edges.
REQ-024 seq_active and code_cur SHALL be registered and SHALL update on the same edge as the state.
REQ-025 cnt SHALL be CODE_W bits and gcnt 8 bits; no counter ever wraps under legal parameters.
REQ-026 The maximum code, 2^CODE_W-1, SHALL flash fully, e.g. 15 flashes for CODE_W=4.

Reset
REQ-027 While rst=1, all of the following SHALL be 0 asynchronously: s1, s2, s3, pending, cur, cnt, gcnt, led_out, seq_active, code_cur. The state SHALL be IDLE.
REQ-028 rst asserted mid-sequence SHALL abort immediately. After release, the block stays in IDLE until a new code_load of a non-zero code and a subsequent tick.
REQ-029 After rst release, the first tick SHALL NOT be generated unless beat_in is seen rising after release.

Verification
REQ-030 No load; beat_in toggling every 8 clk -> led_out equals beat_in delayed 3 clk, seq_active=0, code_cur=0.
REQ-031 Load code 3, GAP_TICKS=4 -> led_out pattern per tick: 1,0,1,0,1,0, then 0 for 4 ticks, then the pattern repeats. code_cur=3, seq_active=1 from the first tick.
REQ-032 Code 3 active; load 5 during the second ON -> the current sequence completes 3 flashes, then the next sequence after the gap shows 5 flashes with code_cur=5.
REQ-033 Code 2 active; load 0 during OFF -> the 2 flashes complete, then the gap, then IDLE with code_cur=0 and led_out following the heartbeat.
REQ-034 Code 15 with CODE_W=4 -> exactly 15 ON ticks before the gap. Also, code_load and tick in the same cycle while in IDLE -> the new code is latched 1 tick later, not in that cycle.
REQ-035 rst pulsed for 1 clk during GAP -> all outputs are 0 within the reset cycle. After release, with pending=0, the block stays in IDLE and mirrors beat_in.
